// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM serving byte/half/word loads and stores with programmable wait states.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        asrst_n,
  input  logic        req_vld,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_rden,
  input  logic        req_rden_SEXT,
  input  logic [3:0]  req_wren,
  input  logic [31:0] req_wrdata,
  output logic        rsp_vld,
  output logic [31:0] rsp_rddata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [31:0] q_addr, q_wrdata, addr, wrdata, word, field, ld, wdata_sh;
  logic [3:0] q_rden, q_wren, rden, wren, m, lanes;
  logic q_sext, sext, accept, go, sel, err;
  logic [1:0] o;
  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = asrst_n && state != WAIT;
  assign accept = req_vld && req_ready;

  always_ff @(posedge clk or negedge asrst_n)
    if (!asrst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == WAIT) begin
      state_nxt = cnt == 4'd0 ? RESP : WAIT;
      cnt_nxt   = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
    end else begin
      state_nxt = accept ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE;
      cnt_nxt   = accept && WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
    end
  end

  // Entering RESP from WAIT serves the captured request; otherwise the one being accepted now.
  assign go     = state_nxt == RESP;
  assign sel    = state == WAIT;
  assign addr   = sel ? q_addr   : req_addr;
  assign rden   = sel ? q_rden   : req_rden;
  assign wren   = sel ? q_wren   : req_wren;
  assign sext   = sel ? q_sext   : req_rden_SEXT;
  assign wrdata = sel ? q_wrdata : req_wrdata;

  assign o   = addr[1:0];
  assign m   = rden | wren;
  assign err = (|rden && |wren) || !(m inside {4'h0, 4'h1, 4'h3, 4'hF}) ||
               (m == 4'h3 && o[0]) || (m == 4'hF && o != 2'd0) ||
               (|m && {2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));

  assign word     = mem[addr[AW+1:2]];
  assign field    = word >> {o, 3'b000};
  assign ld       = rden == 4'h1 ? {{24{sext & field[7]}}, field[7:0]} :
                    rden == 4'h3 ? {{16{sext & field[15]}}, field[15:0]} :
                    rden == 4'hF ? field : 32'd0;
  assign lanes    = wren << o;
  assign wdata_sh = wrdata << {o, 3'b000};

  always_ff @(posedge clk)
    if (go && !err)
      for (int i = 0; i < 4; i++)
        if (lanes[i]) mem[addr[AW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];

  always_ff @(posedge clk or negedge asrst_n)
    if (!asrst_n) begin
      q_addr   <= 32'd0;
      q_rden   <= 4'd0;
      q_wren   <= 4'd0;
      q_sext   <= 1'b0;
      q_wrdata <= 32'd0;
    end else if (accept) begin
      q_addr   <= req_addr;
      q_rden   <= req_rden;
      q_wren   <= req_wren;
      q_sext   <= req_rden_SEXT;
      q_wrdata <= req_wrdata;
    end

  always_ff @(posedge clk or negedge asrst_n)
    if (!asrst_n) begin
      rsp_vld    <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rddata <= 32'd0;
    end else begin
      rsp_vld    <= go;
      rsp_err    <= go && err;
      rsp_rddata <= go && !err ? ld : 32'd0;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks on a zero-wait instance (a_) and a three-wait instance (b_).
module tb_data_mem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst_n, a_vld, a_ready, a_sext, a_rv, a_re;
  logic [31:0] a_addr, a_wdata, a_rd;
  logic [3:0] a_rden, a_wren;
  logic b_rst_n, b_vld, b_ready, b_sext, b_rv, b_re;
  logic [31:0] b_addr, b_wdata, b_rd;
  logic [3:0] b_rden, b_wren;
  int errors = 0;
  int checks = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut_a (
    .clk(clk), .asrst_n(a_rst_n), .req_vld(a_vld), .req_ready(a_ready), .req_addr(a_addr),
    .req_rden(a_rden), .req_rden_SEXT(a_sext), .req_wren(a_wren), .req_wrdata(a_wdata),
    .rsp_vld(a_rv), .rsp_rddata(a_rd), .rsp_err(a_re));

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .asrst_n(b_rst_n), .req_vld(b_vld), .req_ready(b_ready), .req_addr(b_addr),
    .req_rden(b_rden), .req_rden_SEXT(b_sext), .req_wren(b_wren), .req_wrdata(b_wdata),
    .rsp_vld(b_rv), .rsp_rddata(b_rd), .rsp_err(b_re));

  task automatic a_xfer(input logic [31:0] addr, input logic [3:0] rd, input logic s,
                        input logic [3:0] wr, input logic [31:0] wd,
                        output logic v, output logic e, output logic [31:0] d);
    a_vld = 1'b1; a_addr = addr; a_rden = rd; a_sext = s; a_wren = wr; a_wdata = wd;
    @(posedge clk); #1;
    a_vld = 1'b0;
    v = a_rv; e = a_re; d = a_rd;
  endtask

  task automatic b_set(input logic vld, input logic [31:0] addr, input logic [3:0] rd,
                       input logic [3:0] wr, input logic [31:0] wd);
    b_vld = vld; b_addr = addr; b_rden = rd; b_sext = 1'b0; b_wren = wr; b_wdata = wd;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b/%b expected 0/0", a_ready, b_ready); end
    checks++; if ({a_rv, a_re, a_rd} !== 33'd0 || {b_rv, b_re, b_rd} !== 33'd0) begin errors++; $display("FAIL reset_outputs: got a=%b%b%h b=%b%b%h expected zeros", a_rv, a_re, a_rd, b_rv, b_re, b_rd); end
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b/%b expected 1/1", a_ready, b_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    a_vld = 1'b1; a_addr = 32'h10; a_rden = 4'h0; a_sext = 1'b0; a_wren = 4'hF; a_wdata = 32'hDEADBEEF;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t0: got %b expected 1", a_ready); end
    @(posedge clk); #1;
    checks++; if ({a_rv, a_re, a_rd} !== {1'b1, 1'b0, 32'd0}) begin errors++; $display("FAIL b2b_store_rsp: got vld=%b err=%b data=%h expected 1 0 0", a_rv, a_re, a_rd); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t1: got %b expected 1", a_ready); end
    a_rden = 4'hF; a_wren = 4'h0; a_wdata = 32'h0;
    @(posedge clk); #1;
    a_vld = 1'b0;
    checks++; if ({a_rv, a_re, a_rd} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL b2b_load_rsp: got vld=%b err=%b data=%h expected 1 0 deadbeef", a_rv, a_re, a_rd); end
    @(posedge clk); #1;
    checks++; if ({a_rv, a_rd} !== 33'd0) begin errors++; $display("FAIL b2b_idle: got vld=%b data=%h expected 0 0", a_rv, a_rd); end
  endtask

  task automatic test_extension;
    logic v, e; logic [31:0] d;
    a_xfer(32'h10, 4'h0, 1'b0, 4'hF, 32'h8081F2F3, v, e, d);
    a_xfer(32'h11, 4'h1, 1'b1, 4'h0, 32'h0, v, e, d);
    checks++; if ({v, e, d} !== {1'b1, 1'b0, 32'hFFFFFFF2}) begin errors++; $display("FAIL byte_sext: got %b %b %h expected 1 0 fffffff2", v, e, d); end
    a_xfer(32'h11, 4'h1, 1'b0, 4'h0, 32'h0, v, e, d);
    checks++; if (d !== 32'h000000F2) begin errors++; $display("FAIL byte_zext: got %h expected 000000f2", d); end
    a_xfer(32'h12, 4'h3, 1'b1, 4'h0, 32'h0, v, e, d);
    checks++; if (d !== 32'hFFFF8081) begin errors++; $display("FAIL half_sext: got %h expected ffff8081", d); end
    a_xfer(32'h12, 4'h3, 1'b0, 4'h0, 32'h0, v, e, d);
    checks++; if (d !== 32'h00008081) begin errors++; $display("FAIL half_zext: got %h expected 00008081", d); end
    a_xfer(32'h13, 4'h1, 1'b1, 4'h0, 32'h0, v, e, d);
    checks++; if (d !== 32'hFFFFFF80) begin errors++; $display("FAIL byte3_sext: got %h expected ffffff80", d); end
  endtask

  task automatic test_byte_lanes;
    logic v, e; logic [31:0] d;
    a_xfer(32'h08, 4'h0, 1'b0, 4'hF, 32'h0, v, e, d);
    a_xfer(32'h0A, 4'h0, 1'b0, 4'h3, 32'h1234ABCD, v, e, d);
    a_xfer(32'h08, 4'hF, 1'b0, 4'h0, 32'h0, v, e, d);
    checks++; if (d !== 32'hABCD0000) begin errors++; $display("FAIL half_store_lanes: got %h expected abcd0000", d); end
    a_xfer(32'h09, 4'h0, 1'b0, 4'h1, 32'h00000077, v, e, d);
    a_xfer(32'h08, 4'hF, 1'b0, 4'h0, 32'h0, v, e, d);
    checks++; if (d !== 32'hABCD7700) begin errors++; $display("FAIL byte_store_lane1: got %h expected abcd7700", d); end
  endtask

  task automatic test_errors;
    logic v, e; logic [31:0] d;
    a_xfer(32'h00, 4'h0, 1'b0, 4'hF, 32'h11223344, v, e, d);
    a_xfer(32'h02, 4'hF, 1'b0, 4'h0, 32'h0, v, e, d);
    checks++; if ({v, e, d} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL err_word_misaligned: got %b %b %h expected 1 1 0", v, e, d); end
    a_xfer(32'h03, 4'h0, 1'b0, 4'h3, 32'h0000FFFF, v, e, d);
    checks++; if ({v, e, d} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL err_half_odd: got %b %b %h expected 1 1 0", v, e, d); end
    a_xfer(32'h1000, 4'hF, 1'b0, 4'h0, 32'h0, v, e, d);
    checks++; if ({v, e, d} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL err_range: got %b %b %h expected 1 1 0", v, e, d); end
    a_xfer(32'h00, 4'h1, 1'b0, 4'h1, 32'h000000FF, v, e, d);
    checks++; if ({v, e, d} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL err_rd_and_wr: got %b %b %h expected 1 1 0", v, e, d); end
    a_xfer(32'h00, 4'h0, 1'b0, 4'h5, 32'hFFFFFFFF, v, e, d);
    checks++; if ({v, e, d} !== {1'b1, 1'b1, 32'd0}) begin errors++; $display("FAIL err_bad_mask: got %b %b %h expected 1 1 0", v, e, d); end
    a_xfer(32'h00, 4'hF, 1'b0, 4'h0, 32'h0, v, e, d);
    checks++; if ({v, e, d} !== {1'b1, 1'b0, 32'h11223344}) begin errors++; $display("FAIL err_ram_unchanged: got %b %b %h expected 1 0 11223344", v, e, d); end
    a_xfer(32'h00, 4'h0, 1'b0, 4'h0, 32'h0, v, e, d);
    checks++; if ({v, e, d} !== {1'b1, 1'b0, 32'd0}) begin errors++; $display("FAIL noop: got %b %b %h expected 1 0 0", v, e, d); end
  endtask

  task automatic test_wait_states;
    b_set(1'b1, 32'h20, 4'h0, 4'hF, 32'hCAFEF00D);
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL wait_ready_t0: got %b expected 1", b_ready); end
    @(posedge clk); #1;
    b_set(1'b1, 32'h20, 4'hF, 4'h0, 32'h0);
    for (int t = 1; t <= 3; t++) begin
      checks++; if ({b_ready, b_rv, b_rd} !== 34'd0) begin errors++; $display("FAIL wait_t%0d: got ready=%b vld=%b data=%h expected 0 0 0", t, b_ready, b_rv, b_rd); end
      @(posedge clk); #1;
    end
    checks++; if ({b_rv, b_re, b_rd, b_ready} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin errors++; $display("FAIL wait_rsp_t4: got vld=%b err=%b data=%h ready=%b expected 1 0 0 1", b_rv, b_re, b_rd, b_ready); end
    @(posedge clk); #1;
    b_vld = 1'b0;
    for (int t = 5; t <= 7; t++) begin
      checks++; if ({b_ready, b_rv} !== 2'b00) begin errors++; $display("FAIL held_load_wait_t%0d: got ready=%b vld=%b expected 0 0", t, b_ready, b_rv); end
      @(posedge clk); #1;
    end
    checks++; if ({b_rv, b_re, b_rd} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin errors++; $display("FAIL held_load_rsp_t8: got vld=%b err=%b data=%h expected 1 0 cafef00d", b_rv, b_re, b_rd); end
    @(posedge clk); #1;
    checks++; if (b_rv !== 1'b0) begin errors++; $display("FAIL wait_pulse_width: got vld=%b expected 0", b_rv); end
  endtask

  task automatic test_reset_mid_op;
    int seen = 0;
    b_set(1'b1, 32'h20, 4'h0, 4'hF, 32'h12345678);
    @(posedge clk); #1;
    b_vld = 1'b0;
    @(posedge clk); #1;
    b_rst_n = 1'b0;
    #1;
    checks++; if ({b_ready, b_rv, b_re, b_rd} !== 35'd0) begin errors++; $display("FAIL midreset_outputs: got ready=%b vld=%b err=%b data=%h expected zeros", b_ready, b_rv, b_re, b_rd); end
    @(posedge clk); #1;
    b_rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      if (b_rv) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_rsp: got %0d pulses expected 0", seen); end
    b_set(1'b1, 32'h20, 4'hF, 4'h0, 32'h0);
    @(posedge clk); #1;
    b_vld = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if ({b_rv, b_re, b_rd} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin errors++; $display("FAIL midreset_ram_kept: got vld=%b err=%b data=%h expected 1 0 cafef00d", b_rv, b_re, b_rd); end
  endtask

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_vld = 1'b0; a_addr = '0; a_rden = '0; a_sext = 1'b0; a_wren = '0; a_wdata = '0;
    b_set(1'b0, 32'h0, 4'h0, 4'h0, 32'h0);
    repeat (2) @(posedge clk);
    test_reset;
    test_back_to_back;
    test_extension;
    test_byte_lanes;
    test_errors;
    test_wait_states;
    test_reset_mid_op;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
